// File: rtl/imem_shift_buffer.sv
// ----------------------------------------------------------------------------
// imem_shift_buffer
//
// Instruction memory that sits between the instruction loader (write side) and
// the fetch stage (read side). The loader writes words in one of two ways:
// it can shift them in at entry 0, pushing older words toward the top, or it
// can write them directly to an addressed entry. The memory tracks which
// entries are valid, counts them and flags when every entry is full. The
// fetch stage gets a registered read port, and each read result says whether
// the addressed entry was valid.
//
// Parameters
//   WIDTH   data word width
//   DEPTH   number of entries (2 .. 2**ADDR_W)
//   ADDR_W  address width
//   CNT_W   occupancy counter width, must be able to hold DEPTH
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   wr_valid  write request
//   wr_ready  write may be accepted (~rst & ~lock), combinational
//   wr_mode   0 = shift-insert at entry 0, 1 = direct write at wr_addr
//   wr_addr   direct-write target
//   wr_data   write word
//   lock      blocks all writes while high; reads continue
//   clear     synchronous clear of entries, valid bits and count
//   rd_en     read request
//   rd_addr   read address
//   rd_data   registered read data (holds when no read is issued)
//   rd_valid  rd_data answers the request made on the previous cycle
//   rd_hit    addressed entry held valid data
//   count     number of valid entries
//   full      count == DEPTH
// ----------------------------------------------------------------------------
module imem_shift_buffer #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_mode,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              lock,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_hit,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  // The depth is compared against a zero-extended address. That keeps the
  // range check correct when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]  DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;

  logic             wr_fire;
  logic             wr_in_range;
  logic             rd_in_range;
  logic             count_inc;

  // ---------------------------------------------------------------------------
  // Write handshake and address qualification
  // ---------------------------------------------------------------------------
  assign wr_ready    = ~rst & ~lock;
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_A);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_A);

  // ---------------------------------------------------------------------------
  // Occupancy is updated incrementally instead of recounting every bit.
  // In shift mode, a valid top entry falls off the end as the new word comes
  // in at entry 0, so the count stays the same. For that reason the count can
  // never grow past DEPTH.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_inc = 1'b0;
    if (wr_fire) begin
      if (!wr_mode) begin
        count_inc = ~valid_q[DEPTH-1];
      end else if (wr_in_range) begin
        count_inc = ~valid_q[wr_addr];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(count_inc);
    end
  end

  // ---------------------------------------------------------------------------
  // Storage and valid bits. clear wins over a write on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid_q <= '0;
    end else if (wr_fire) begin
      if (!wr_mode) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          mem[i] <= mem[i-1];
        end
        mem[0]  <= wr_data;
        valid_q <= {valid_q[DEPTH-2:0], 1'b1};
      end else if (wr_in_range) begin
        mem[wr_addr]     <= wr_data;
        valid_q[wr_addr] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Count and full flag. Both registers are updated together, so full never
  // lags count by a cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
    end
  end

  assign count = count_q;
  assign full  = full_q;

  // ---------------------------------------------------------------------------
  // Registered read port. It samples mem and valid_q before this edge's write
  // or clear takes effect, so a read on the same edge as a write returns the
  // old contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_in_range) begin
          rd_data <= mem[rd_addr];
          rd_hit  <= valid_q[rd_addr];
        end else begin
          rd_data <= '0;
          rd_hit  <= 1'b0;
        end
      end else begin
        rd_hit <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_shift_buffer.sv
// ----------------------------------------------------------------------------
// tb_imem_shift_buffer
//
// Bench for imem_shift_buffer, built with DEPTH=48 so that addresses 48..63
// fall outside the memory. A behavioural model holds the memory as a plain
// array plus a valid flag per entry. Occupancy is taken as a direct count of
// the valid flags.
// ----------------------------------------------------------------------------
module tb_imem_shift_buffer;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 48;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 6;

  logic              clk;
  logic              rst;
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_mode;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              lock;
  logic              clear;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              rd_hit;
  logic [CNT_W-1:0]  count;
  logic              full;

  imem_shift_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_mode (wr_mode),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .lock    (lock),
    .clear   (clear),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .rd_hit  (rd_hit),
    .count   (count),
    .full    (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_val [DEPTH];
  logic [WIDTH-1:0] m_rd_data;
  bit               m_rd_valid;
  bit               m_rd_hit;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_val[i] ? 1 : 0;
    return n;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_val[i] = 0;
    end
    m_rd_data  = '0;
    m_rd_valid = 0;
    m_rd_hit   = 0;
  endtask

  // The model reads first, then writes, so a read on a write edge returns the old contents.
  task automatic m_step();
    int ra = int'(rd_addr);
    int wa = int'(wr_addr);
    m_rd_valid = rd_en;
    if (rd_en) begin
      if (ra < DEPTH) begin
        m_rd_data = m_mem[ra];
        m_rd_hit  = m_val[ra];
      end else begin
        m_rd_data = '0;
        m_rd_hit  = 0;
      end
    end else begin
      m_rd_hit = 0;
    end
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_val[i] = 0;
      end
    end else if (wr_valid && !lock) begin
      if (!wr_mode) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          m_mem[i] = m_mem[i-1];
          m_val[i] = m_val[i-1];
        end
        m_mem[0] = wr_data;
        m_val[0] = 1;
      end else if (wa < DEPTH) begin
        m_mem[wa] = wr_data;
        m_val[wa] = 1;
      end
    end
  endtask

  // Inputs must already be driven when this is called. It checks wr_ready,
  // advances the model and the DUT one edge, then compares every output.
  task automatic cycle();
    #1;
    check("wr_ready", wr_ready, !lock);
    m_step();
    @(posedge clk);
    #1;
    check("rd_valid", rd_valid, m_rd_valid);
    check("rd_hit", rd_hit, m_rd_hit);
    check("rd_data", rd_data, m_rd_data);
    check("count", count, m_count());
    check("full", full, m_count() == DEPTH);
  endtask

  task automatic idle();
    wr_valid = 0; wr_mode = 0; wr_addr = '0; wr_data = '0;
    lock = 0; clear = 0; rd_en = 0; rd_addr = '0;
  endtask

  task automatic do_shift(input logic [WIDTH-1:0] d);
    idle(); wr_valid = 1; wr_mode = 0; wr_data = d; cycle();
  endtask

  task automatic do_direct(input int a, input logic [WIDTH-1:0] d);
    idle(); wr_valid = 1; wr_mode = 1; wr_addr = ADDR_W'(a); wr_data = d; cycle();
  endtask

  task automatic do_read(input int a);
    idle(); rd_en = 1; rd_addr = ADDR_W'(a); cycle();
  endtask

  task automatic do_clear();
    idle(); clear = 1; cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst = 1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 0;

    // Test 1: three shift-inserts, then read entries 0..3 back.
    do_shift(16'hAAAA); do_shift(16'hBBBB); do_shift(16'hCCCC);
    do_read(0); check("t1_rd0", rd_data, 16'hCCCC); check("t1_hit0", rd_hit, 1);
    do_read(1); check("t1_rd1", rd_data, 16'hBBBB);
    do_read(2); check("t1_rd2", rd_data, 16'hAAAA);
    do_read(3); check("t1_rd3", rd_data, 0); check("t1_hit3", rd_hit, 0);
    check("t1_count", count, 3); check("t1_full", full, 0);

    // Test 2: shift in DEPTH+1 words. The first one drops off the top.
    do_clear();
    for (int i = 0; i <= DEPTH; i++) do_shift(WIDTH'(i));
    check("t2_count", count, DEPTH); check("t2_full", full, 1);
    do_read(DEPTH - 1); check("t2_top", rd_data, 1);
    do_read(0); check("t2_bottom", rd_data, DEPTH);

    // Test 3: direct writes to the same address, then a shift, then an out-of-range write.
    do_clear();
    do_direct(10, 16'h1234); do_direct(10, 16'h5678);
    check("t3_count1", count, 1);
    do_read(10); check("t3_rd10", rd_data, 16'h5678);
    do_shift(16'h9999);
    do_read(11); check("t3_rd11", rd_data, 16'h5678);
    do_read(0); check("t3_rd0", rd_data, 16'h9999);
    check("t3_count2", count, 2);
    do_direct(63, 16'hDEAD);
    check("t3_oor_count", count, 2);
    do_read(63); check("t3_oor_data", rd_data, 0); check("t3_oor_hit", rd_hit, 0);

    // Test 4: a read on the same edge as a write returns the old contents.
    do_clear();
    idle(); wr_valid = 1; wr_mode = 1; wr_addr = 5; wr_data = 16'hABCD; rd_en = 1; rd_addr = 5;
    cycle();
    check("t4_rbw_data", rd_data, 0); check("t4_rbw_hit", rd_hit, 0);
    do_read(5); check("t4_data", rd_data, 16'hABCD); check("t4_hit", rd_hit, 1);

    // Test 5: lock blocks writes but not reads; clear beats a simultaneous write.
    do_shift(16'h1111);
    for (int i = 0; i < 3; i++) begin
      idle(); lock = 1; wr_valid = 1; wr_data = 16'hF00D; rd_en = 1; rd_addr = 0;
      cycle();
      check("t5_lock_count", count, 2);
      check("t5_lock_rd", rd_valid, 1);
    end
    idle(); clear = 1; wr_valid = 1; wr_data = 16'h7777; cycle();
    check("t5_clear_count", count, 0);
    for (int a = 0; a < 4; a++) begin
      do_read(a); check("t5_clear_hit", rd_hit, 0);
    end

    // Test 6: assert reset in the middle of a cycle while a read result is live.
    for (int i = 0; i < 5; i++) do_shift(WIDTH'(16'h100 + i));
    do_read(2);
    check("t6_pre_valid", rd_valid, 1); check("t6_pre_count", count, 5);
    idle(); rd_en = 1; rd_addr = 1;
    #3 rst = 1;
    #1;
    check("t6_rd_valid", rd_valid, 0); check("t6_rd_data", rd_data, 0);
    check("t6_count", count, 0); check("t6_full", full, 0);
    check("t6_wr_ready", wr_ready, 0);
    m_reset();
    @(posedge clk); #1;
    check("t6_hold_count", count, 0);
    rst = 0;
    idle();
    do_shift(16'h4242);
    check("t6_first_write", count, 1);

    // Random phase: mixed traffic, checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      wr_valid = ($urandom_range(0, 9) < 6);
      wr_mode  = $urandom_range(0, 1) == 1;
      wr_addr  = ADDR_W'($urandom_range(0, 63));
      wr_data  = WIDTH'($urandom);
      lock     = ($urandom_range(0, 9) < 2);
      clear    = ($urandom_range(0, 59) == 0);
      rd_en    = ($urandom_range(0, 9) < 6);
      rd_addr  = ADDR_W'($urandom_range(0, 63));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
